// File: rtl/muu_pkg.sv
// Shared definitions for the sequential multiply/divide unit: op codes, FSM states,
// iteration count and the 64-bit HI/LO result type.
package muu_pkg;

   localparam int XLEN  = 32;
   localparam int ITERS = 32;
   localparam int CNT_W = 6;

   localparam logic [3:0] OP_MUL   = 4'b0000;
   localparam logic [3:0] OP_MULT  = 4'b0001;
   localparam logic [3:0] OP_MADD  = 4'b0010;
   localparam logic [3:0] OP_MSUBU = 4'b0011;
   localparam logic [3:0] OP_DIV   = 4'b0100;
   localparam logic [3:0] OP_MFHI  = 4'b0101;
   localparam logic [3:0] OP_MFLO  = 4'b0110;
   localparam logic [3:0] OP_DIVU  = 4'b0111;
   localparam logic [3:0] OP_MULTU = 4'b1000;
   localparam logic [3:0] OP_MTHI  = 4'b1001;
   localparam logic [3:0] OP_MTLO  = 4'b1010;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUL_ITER,
      ST_DIV_ITER,
      ST_FINAL
   } state_e;

   typedef logic [2*XLEN-1:0] dword_t;

   // Signed ops run on magnitudes and get their sign restored in FINAL.
   function automatic logic is_signed_op(input logic [3:0] op);
      return (op == OP_MUL) || (op == OP_MULT) || (op == OP_MADD) || (op == OP_DIV);
   endfunction

   function automatic logic is_mul_op(input logic [3:0] op);
      return (op == OP_MUL) || (op == OP_MULT) || (op == OP_MADD) ||
             (op == OP_MSUBU) || (op == OP_MULTU);
   endfunction

   function automatic logic is_div_op(input logic [3:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/muu_shift_core.sv
// Shared 64-bit accumulator/shift datapath: shift-add multiply or restoring divide step.
// With MULDIV_EARLY_TERM_EN it also reports when the remaining multiplier is exhausted.
module muu_shift_core
   import muu_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic            step,
   input  logic            div_mode,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output dword_t          result
`ifdef MULDIV_EARLY_TERM_EN
   ,
   output logic            mplier_empty
`endif
);

   dword_t          acc_q, acc_d;
   dword_t          opnd_q, opnd_d;
   logic [XLEN-1:0] mplier_q, mplier_d;
   dword_t          sum;
   logic [XLEN:0]   trial;

   // acc holds {remainder, quotient} in divide mode; the shifted-in remainder never exceeds 33 bits.
   assign sum   = acc_q + opnd_q;
   assign trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opnd_q[XLEN-1:0]};

   always_comb begin
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      mplier_d = mplier_q;
      if (load) begin
         if (div_mode) begin
            acc_d    = {{XLEN{1'b0}}, op_a};
            opnd_d   = {{XLEN{1'b0}}, op_b};
            mplier_d = '0;
         end else begin
            acc_d    = '0;
            opnd_d   = {{XLEN{1'b0}}, op_a};
            mplier_d = op_b;
         end
      end else if (step) begin
         if (div_mode) begin
            if (!trial[XLEN])
               acc_d = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            else
               acc_d = {acc_q[2*XLEN-2:0], 1'b0};
         end else begin
            if (mplier_q[0])
               acc_d = sum;
            opnd_d   = {opnd_q[2*XLEN-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[XLEN-1:1]};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q    <= '0;
         opnd_q   <= '0;
         mplier_q <= '0;
      end else begin
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         mplier_q <= mplier_d;
      end
   end

   assign result = acc_q;

`ifdef MULDIV_EARLY_TERM_EN
   assign mplier_empty = (mplier_q[XLEN-1:1] == '0);
`endif

endmodule

// File: rtl/muu_seq_hilo.sv
// Multi-cycle multiply/divide responder with architectural HI/LO registers.
// Define MULDIV_EARLY_TERM_EN to let multiplies finish once the multiplier is exhausted.
module muu_seq_hilo
   import muu_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [3:0]      operation,
   input  logic [XLEN-1:0] rs,
   input  logic [XLEN-1:0] rt,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] out,
   output logic            div_zero,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [3:0]       op_q, op_d;
   logic             neg_res_q, neg_res_d;
   logic             neg_rem_q, neg_rem_d;
   logic [XLEN-1:0]  hi_q, hi_d, lo_q, lo_d, out_q, out_d;
   logic             done_q, done_d;
   logic             div_zero_q, div_zero_d;

   logic             core_load, core_step, core_div;
   logic             in_signed, mul_last;
   logic [XLEN-1:0]  mag_a, mag_b, quo, rem;
   dword_t           core_result, hilo, prod_signed;

   assign in_signed = is_signed_op(operation);
   assign mag_a     = (in_signed && rs[XLEN-1]) ? -rs : rs;
   assign mag_b     = (in_signed && rt[XLEN-1]) ? -rt : rt;

`ifdef MULDIV_EARLY_TERM_EN
   logic core_empty;

   muu_shift_core u_core (
      .clk          (clk),
      .rst_n        (rst_n),
      .load         (core_load),
      .step         (core_step),
      .div_mode     (core_div),
      .op_a         (mag_a),
      .op_b         (mag_b),
      .result       (core_result),
      .mplier_empty (core_empty)
   );

   assign mul_last = (count_q == CNT_W'(1)) || core_empty;
`else
   muu_shift_core u_core (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (core_load),
      .step     (core_step),
      .div_mode (core_div),
      .op_a     (mag_a),
      .op_b     (mag_b),
      .result   (core_result)
   );

   assign mul_last = (count_q == CNT_W'(1));
`endif

   assign hilo        = {hi_q, lo_q};
   assign prod_signed = neg_res_q ? -core_result : core_result;
   assign quo         = neg_res_q ? -core_result[XLEN-1:0] : core_result[XLEN-1:0];
   assign rem         = neg_rem_q ? -core_result[2*XLEN-1:XLEN] : core_result[2*XLEN-1:XLEN];

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      op_d       = op_q;
      neg_res_d  = neg_res_q;
      neg_rem_d  = neg_rem_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      out_d      = out_q;
      done_d     = 1'b0;
      div_zero_d = div_zero_q;
      core_load  = 1'b0;
      core_step  = 1'b0;
      core_div   = (state_q == ST_DIV_ITER);

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               op_d     = operation;
               core_div = is_div_op(operation);
               if (is_mul_op(operation)) begin
                  core_load = 1'b1;
                  count_d   = CNT_W'(ITERS);
                  neg_res_d = in_signed & (rs[XLEN-1] ^ rt[XLEN-1]);
                  neg_rem_d = 1'b0;
                  state_d   = ST_MUL_ITER;
               end else if (is_div_op(operation) && (rt != '0)) begin
                  core_load = 1'b1;
                  count_d   = CNT_W'(ITERS);
                  neg_res_d = in_signed & (rs[XLEN-1] ^ rt[XLEN-1]);
                  neg_rem_d = in_signed & rs[XLEN-1];
                  state_d   = ST_DIV_ITER;
               end else begin
                  // Short ops and divide-by-zero retire straight from IDLE.
                  done_d     = 1'b1;
                  div_zero_d = is_div_op(operation);
                  case (operation)
                     OP_MFHI: out_d = hi_q;
                     OP_MFLO: out_d = lo_q;
                     OP_MTHI: hi_d  = rs;
                     OP_MTLO: lo_d  = rs;
                     default: ;
                  endcase
               end
            end
         end

         ST_MUL_ITER: begin
            core_step = 1'b1;
            count_d   = count_q - CNT_W'(1);
            if (mul_last)
               state_d = ST_FINAL;
         end

         ST_DIV_ITER: begin
            core_step = 1'b1;
            count_d   = count_q - CNT_W'(1);
            if (count_q == CNT_W'(1))
               state_d = ST_FINAL;
         end

         ST_FINAL: begin
            done_d     = 1'b1;
            div_zero_d = 1'b0;
            state_d    = ST_IDLE;
            case (op_q)
               OP_MUL:           out_d        = prod_signed[XLEN-1:0];
               OP_MULT:          {hi_d, lo_d} = prod_signed;
               OP_MADD:          {hi_d, lo_d} = hilo + prod_signed;
               OP_MSUBU:         {hi_d, lo_d} = hilo - core_result;
               OP_MULTU:         {hi_d, lo_d} = core_result;
               OP_DIV, OP_DIVU: begin
                  lo_d = quo;
                  hi_d = rem;
               end
               default: ;
            endcase
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         count_q    <= '0;
         op_q       <= '0;
         neg_res_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         out_q      <= '0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         op_q       <= op_d;
         neg_res_q  <= neg_res_d;
         neg_rem_q  <= neg_rem_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         out_q      <= out_d;
         done_q     <= done_d;
         div_zero_q <= div_zero_d;
      end
   end

   assign busy     = (state_q != ST_IDLE);
   assign done     = done_q;
   assign out      = out_q;
   assign div_zero = div_zero_q;
   assign hi       = hi_q;
   assign lo       = lo_q;

endmodule

// File: doc/muu_seq_hilo.md
Name: muu_seq_hilo

Overview:
Multi-cycle sequential multiply/divide responder with architectural HI/LO registers.
- The pipeline control issues an op with a start pulse, stalls on busy, and collects results on a done pulse.
- Serves as the back end of the MULT/DIV/MADD/MSUBU/MFHI/MFLO instruction path.
- Replaces a single-cycle combinational multiply/divide with a 32-iteration shift datapath.

Parameters:
- XLEN, 32, operand width; fixed at 32 for this core.
- ITERS, 32, shift/subtract iterations per long op.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset
- start  input  1  op request; accepted only when busy=0
- operation  input  4  op code (see Behaviour)
- rs  input  32  operand A / dividend / multiplicand
- rt  input  32  operand B / divisor / multiplier
- busy  output  1  long op in progress; pipeline stalls while high
- done  output  1  one-cycle pulse: op complete, out/div_zero valid
- out  output  32  result for MUL/MFHI/MFLO; held until next done
- div_zero  output  1  registered; valid with done; set on DIV/DIVU with rt=0
- hi  output  32  architectural HI (read-only view)
- lo  output  32  architectural LO (read-only view)

Behaviour:
- Reset (rst_n=0 at edge): state=IDLE; busy=0, done=0, out=0, div_zero=0, hi=0, lo=0; any in-flight op is discarded with no done. Reset takes priority over start.
- Op codes:
  - 0000 MUL: out=low 32 bits of signed product; HI/LO unchanged.
  - 0001 MULT: {HI,LO}=signed product.
  - 0010 MADD: {HI,LO}+=signed product, 64-bit add with carry from LO into HI.
  - 0011 MSUBU: {HI,LO}-=unsigned product, 64-bit.
  - 0100 DIV: signed; LO=quotient, HI=remainder.
  - 0101 MFHI: out=HI.
  - 0110 MFLO: out=LO.
  - 0111 DIVU: unsigned DIV.
  - 1000 MULTU: {HI,LO}=unsigned product.
  - 1001 MTHI: HI=rs.
  - 1010 MTLO: LO=rs.
  - Others: no-op; done pulses after 1 cycle, all registers unchanged.
- States: IDLE, MUL_ITER, DIV_ITER, FINAL.
  - IDLE + start + long op (MUL, MULT, MADD, MSUBU, MULTU, DIV, DIVU with rt≠0): latch operands and op, load counter=ITERS, go to MUL_ITER or DIV_ITER; busy=1 from the next cycle.
  - MUL_ITER: radix-2 shift-add on magnitudes; counter decrements; at counter=1 go to FINAL.
  - DIV_ITER: restoring divide, one quotient bit per cycle; at counter=1 go to FINAL.
  - FINAL: apply signs, update HI/LO/out, pulse done, drop busy, return to IDLE.
  - Latency: start edge to done = ITERS+2 cycles (34). A new start is legal in the cycle done is high.
- Short ops (MFHI, MFLO, MTHI, MTLO, no-op, divide-by-zero): complete from IDLE in 1 cycle with no busy; done and out (or HI/LO) update at the edge after start.
  - MFHI issued back-to-back after a long op returns the already-updated HI.
- Sign rules:
  - Operate on magnitudes; product sign = sign(rs) XOR sign(rt).
  - Quotient negated if operand signs differ; remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF (signed): LO=0x80000000, HI=0; no exception.
- Divide by zero: div_zero=1 with done; HI/LO unchanged. div_zero clears on the next done.
- start while busy=1: ignored; the op, operands and HI/LO are unaffected.
- Arithmetic is modulo 2^64 on {HI,LO}; no overflow flag.

Optional Feature:
- MULDIV_EARLY_TERM_EN defined: multiply ops leave MUL_ITER once the remaining multiplier magnitude is zero, so latency = (index of highest set bit of |rt|)+3 cycles (min 3). Divide latency stays fixed. done/busy semantics are unchanged.
- Undefined: all long ops take a fixed ITERS+2 cycles.

Decomposition:
- Package muu_pkg:
  - op code localparams (OP_MUL … OP_MTLO)
  - state enum
  - ITERS default
  - 64-bit result type
- One sub-module: muu_shift_core, the shared 64-bit accumulator / shift register with add (multiply) and trial-subtract (divide) step, controlled by a mode bit. The FSM, sign fix-up and HI/LO registers stay in the top level.

Test Plan:
- Reset mid-op: start MULT, assert rst_n=0 at cycle 10 → no done, busy=0, hi=lo=0.
- MULT 0xFFFFFFFF × 0x00000002 → done at cycle 34; hi=0xFFFFFFFF, lo=0xFFFFFFFE; then MFHI → out=0xFFFFFFFF after 1 cycle.
- DIV −7 / 2 → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1); DIVU 7/2 → lo=3, hi=1.
- MADD hi=0, lo=0xFFFFFFFF, rs=1, rt=1 → hi=1, lo=0; then MSUBU rs=1, rt=1 → hi=0, lo=0xFFFFFFFF.
- DIV rt=0 → done after 1 cycle with div_zero=1, HI/LO unchanged; a start issued while busy is ignored.
- MUL 0x00010000 × 0x00010000 → out=0, HI/LO unchanged; with MULDIV_EARLY_TERM_EN, MULT rs=5, rt=1 → done at cycle 3.
